// File: rtl/adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [DEFAULT_WIDTH-1:0] sum_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full-adder cell; chained by full_adder_32bit into a ripple adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign s       = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule

// File: rtl/full_adder_32bit.sv
// Registered A+B+Cin ripple-carry adder with carry-out and signed overflow.
// One clock of latency, one operation per cycle, no backpressure.
module full_adder_32bit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             overflow_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             overflow_q;
    logic             valid_q;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder_1bit u_cell (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_d[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow: the carry into the MSB disagrees with the carry out of it.
    assign cout_d     = carry[WIDTH];
    assign overflow_d = carry[WIDTH-1] ^ carry[WIDTH];

    // Outputs load every edge; consumers qualify them with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            valid_q    <= in_valid;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_32bit.sv
// Scoreboard bench for full_adder_32bit: expected results queued at drive time,
// popped and compared one cycle later.
module tb_full_adder_32bit;
    import adder_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    sum_t A;
    sum_t B;
    logic Cin;
    logic in_valid;
    sum_t Sum;
    logic Cout;
    logic Overflow;
    logic out_valid;

    int   checks   = 0;
    int   failures = 0;
    exp_t scoreboard[$];

    full_adder_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model uses a 33-bit sum and the sign-rule for overflow.
    function automatic exp_t model(sum_t a, sum_t b, logic cin, logic v);
        logic [32:0] full;
        exp_t        e;
        full    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        e.sum   = full[31:0];
        e.cout  = full[32];
        e.ovf   = (a[31] == b[31]) && (full[31] != a[31]);
        e.valid = v;
        return e;
    endfunction

    task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input sum_t a, input sum_t b, input logic cin, input logic v);
        @(negedge clk);
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = v;
        scoreboard.push_back(model(a, b, cin, v));
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s: observed=no-expected-entry expected=queued-result", tag);
        end else begin
            e = scoreboard.pop_front();
            compare({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.valid});
            compare({tag, ".sum"},   Sum,                e.sum);
            compare({tag, ".cout"},  {31'd0, Cout},      {31'd0, e.cout});
            compare({tag, ".ovf"},   {31'd0, Overflow},  {31'd0, e.ovf});
        end
    endtask

    task automatic checkReset(input string tag);
        compare({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        compare({tag, ".sum"},   Sum,                32'd0);
        compare({tag, ".cout"},  {31'd0, Cout},      32'd0);
        compare({tag, ".ovf"},   {31'd0, Overflow},  32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset_initial");

        // Release between edges with stimulus already waiting.
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(32'd5465, 32'd52, 1'b0, 1'b1);
        checkOutput("add_5465_52");
        applyStimulus(32'd5895, 32'd52, 1'b0, 1'b1);
        checkOutput("add_5895_52");
        applyStimulus(32'd245, 32'd52, 1'b0, 1'b1);
        checkOutput("add_245_52");
        applyStimulus(32'd5, 32'd2, 1'b0, 1'b1);
        checkOutput("add_5_2");

        applyStimulus(32'd8, 32'd5254, 1'b1, 1'b1);
        checkOutput("cin_8_5254");
        applyStimulus(32'd0, 32'd0, 1'b1, 1'b1);
        checkOutput("cin_zero");

        applyStimulus(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        checkOutput("wrap_ones_plus_cin");
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        checkOutput("wrap_ones_ones_cin");

        applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        checkOutput("ovf_pos");
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        checkOutput("ovf_neg");

        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), ((i % 2) == 0));
            checkOutput($sformatf("alt_valid_%0d", i));
        end

        // Mid-stream reset between edges drops the pending result at once.
        applyStimulus($urandom, $urandom, 1'b1, 1'b1);
        checkOutput("pre_reset");
        #2;
        rst = 1'b1;
        #1;
        checkReset("reset_async");
        scoreboard.delete();
        #1;
        rst = 1'b0;

        applyStimulus(32'd100, 32'd200, 1'b1, 1'b1);
        checkOutput("post_release");
        applyStimulus(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
        checkOutput("post_release_b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
